// File: rtl/or_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : or_chk_pkg
//  Description : Shared types, default sizes and golden model for the
//                3-input OR response checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package or_chk_pkg;

    // Default number of gate inputs and width of the pass/fail counters
    localparam int N_IN_DEF  = 3;
    localparam int CNT_W_DEF = 8;

    // Widest input vector the golden model accepts; narrower vectors are zero-extended
    localparam int MAX_IN    = 16;

    // Checker run state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    // Golden model: the gate output is the OR of all inputs
    function automatic logic or_expected(input logic [MAX_IN-1:0] vec);
        return |vec;
    endfunction

endpackage : or_chk_pkg
`default_nettype wire

// File: rtl/or3_response_checker_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter with synchronous clear that sticks at all-ones
//                instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear has priority over increment; increment stops at the maximum value
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/or3_response_checker.sv
`default_nettype none
// ============================================================================
//  Module      : or3_response_checker
//  Description : Consumes (vector, observed Y) samples from an OR gate under
//                test, compares them against the golden OR, counts passes and
//                failures, tracks input-space coverage and latches the first
//                failing sample. A run ends once every combination was seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module or3_response_checker
    import or_chk_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [N_IN-1:0]      vec_i,
    input  logic                 y_i,
    output logic [CNT_W-1:0]     pass_cnt_o,
    output logic [CNT_W-1:0]     fail_cnt_o,
    output logic [(1<<N_IN)-1:0] coverage_o,
    output logic                 first_fail_valid_o,
    output logic [N_IN-1:0]      first_fail_vec_o,
    output logic                 first_fail_y_o,
    output logic                 done_o,
    output logic                 pass_o
);

    localparam int COV_W = 1 << N_IN;

    chk_state_t       state_q, state_d;
    logic [COV_W-1:0] cov_q, cov_d;
    logic             ff_valid_q, ff_valid_d;
    logic [N_IN-1:0]  ff_vec_q, ff_vec_d;
    logic             ff_y_q, ff_y_d;

    logic             xfer;
    logic             mismatch;
    logic [COV_W-1:0] cov_upd;

    // A sample is consumed only while running; a coinciding start discards it
    assign xfer     = in_valid_i && (state_q == RUN) && !start_i;
    assign mismatch = (y_i != or_expected(MAX_IN'(vec_i)));
    assign cov_upd  = cov_q | (COV_W'(1) << vec_i);

    // Next-state logic for the FSM, coverage map and first-fail capture
    always_comb begin
        state_d    = state_q;
        cov_d      = cov_q;
        ff_valid_d = ff_valid_q;
        ff_vec_d   = ff_vec_q;
        ff_y_d     = ff_y_q;

        if (start_i) begin
            state_d    = RUN;
            cov_d      = '0;
            ff_valid_d = 1'b0;
            ff_vec_d   = '0;
            ff_y_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                RUN: begin
                    if (xfer) begin
                        cov_d = cov_upd;
                        if (mismatch && !ff_valid_q) begin
                            ff_valid_d = 1'b1;
                            ff_vec_d   = vec_i;
                            ff_y_d     = y_i;
                        end
                        if (&cov_upd) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cov_q      <= '0;
            ff_valid_q <= 1'b0;
            ff_vec_q   <= '0;
            ff_y_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cov_q      <= cov_d;
            ff_valid_q <= ff_valid_d;
            ff_vec_q   <= ff_vec_d;
            ff_y_q     <= ff_y_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (start_i),
        .inc_i (xfer && !mismatch),
        .cnt_o (pass_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (start_i),
        .inc_i (xfer && mismatch),
        .cnt_o (fail_cnt_o)
    );

    // Handshake and verdict are pure decodes of registered state
    assign in_ready_o         = (state_q == RUN);
    assign done_o             = (state_q == DONE);
    assign pass_o             = done_o && (fail_cnt_o == '0);
    assign coverage_o         = cov_q;
    assign first_fail_valid_o = ff_valid_q;
    assign first_fail_vec_o   = ff_vec_q;
    assign first_fail_y_o     = ff_y_q;

endmodule : or3_response_checker
`default_nettype wire

// File: doc/or3_response_checker.md
# or3_response_checker

Self-checking response monitor for the 3-input OR data-flow gate: the consuming end of the stimulus stream that drives A/B/C into the gate. Each accepted sample (input vector plus observed Y) is compared against the golden OR of the inputs. The block counts passes and failures, tracks coverage of all 2^N_IN input combinations, and captures the first failing vector. It sits beside the gate in the quiz bench and in on-board self-test, and replaces eyeballing `$monitor` output with a pass/fail verdict.

## Interface
- N_IN, 3, number of gate inputs; vector width, coverage map is 2^N_IN bits
- CNT_W, 8, width of pass/fail counters
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; clears all results and begins a check run
- in_valid  in  1  sample present on vec/y
- in_ready  out  1  checker accepts sample this cycle
- vec  in  N_IN  input vector applied to the gate; bit2 = A, bit1 = B, bit0 = C
- y  in  1  observed gate output for vec
- pass_cnt  out  CNT_W  matching samples, saturating
- fail_cnt  out  CNT_W  mismatching samples, saturating
- coverage  out  2^N_IN  bit k set once vec == k has been accepted
- first_fail_valid  out  1  a mismatch has been captured this run
- first_fail_vec  out  N_IN  vec of the first mismatch
- first_fail_y  out  1  observed y of the first mismatch
- done  out  1  run complete: every combination covered
- pass  out  1  done && fail_cnt == 0

## Operation
- States: IDLE, RUN, DONE. Package enum chk_state_t.
- IDLE: in_ready = 0.
  - start → RUN, clearing the counters, coverage and first_fail_*.
- RUN: in_ready = 1. A transfer occurs when in_valid && in_ready.
  - expected = |vec.
  - y == expected → pass_cnt++; otherwise fail_cnt++.
  - coverage[vec] is set on every transfer.
  - On the first mismatch only, capture vec and y into first_fail_* and set first_fail_valid.
  - When the coverage update makes coverage all ones → DONE.
  - Duplicate vectors are counted normally and do not change coverage.
- DONE: in_ready = 0; done = 1; results hold.
  - start → RUN with a full clear.
- start in RUN restarts the run: clear everything and stay in RUN. If a transfer coincides with start, it is discarded (start wins).
- Counters saturate at 2^CNT_W−1 and never wrap.
- Reset values: state IDLE; in_ready 0; pass_cnt 0; fail_cnt 0; coverage 0; first_fail_valid 0; first_fail_vec 0; first_fail_y 0; done 0; pass 0.
- rst mid-run returns to IDLE with all outputs at reset values. The next start is required to resume.

## Timing
- All outputs are registered.
- A transfer in cycle t is visible in pass_cnt, fail_cnt, coverage and first_fail_* at t+1.
- The transfer that completes coverage produces done = 1 and in_ready = 0 at t+1. A sample offered at t+1 is not accepted.
- start at t gives in_ready = 1 and cleared outputs at t+1.
- Back-to-back transfers are accepted every cycle; throughput is 1 sample/clk.
- in_valid is ignored whenever in_ready = 0; no state changes.
- pass is combinational from registered done and fail_cnt, so it is glitch-free relative to clk.

## Structure
- Package or_chk_pkg holds:
  - chk_state_t
  - the default N_IN and CNT_W
  - a function or_expected(vec) returning |vec (the golden model)
- One sub-module, sat_counter (CNT_W wide, inc, clr, saturating), is instantiated twice for pass_cnt and fail_cnt.
- FSM, coverage register and first-fail capture live in the top module.

## Test plan
- Exhaustive correct stream: start, then vec 0..7 with y = |vec on consecutive cycles.
  - Required: pass_cnt = 8, fail_cnt = 0, coverage = 8'hFF, done = 1 and pass = 1 one cycle after the 8th transfer, in_ready = 0.
- Injected fault: the same stream with y = 0 at vec = 3'b101 and y = 1 at vec = 3'b000.
  - Required: fail_cnt = 2, first_fail_vec = 3'b000, first_fail_y = 1, first_fail_valid = 1, pass = 0 after done.
- Duplicates and gaps: vec 1, 1, 1, then idle cycles with in_valid = 0, then 0, 2..7.
  - Required: pass_cnt = 10, coverage = 8'hFF, done asserted only after the 10th transfer.
- Saturation: CNT_W = 2, twelve samples with vec = 3'b111, y = 1.
  - Required: pass_cnt holds at 3, coverage = 8'h80, done = 0.
- Reset mid-run: after 4 transfers assert rst for 1 cycle.
  - Required: all outputs at reset values, in_ready = 0, samples ignored until start.
- Restart collision: start coincides with a valid transfer in RUN.
  - Required: counters and coverage are 0 at the next cycle, and the sample is not counted.
